// File: rtl/cmd_dispatch.sv
// Command dispatcher: executes 16-bit UART commands against a byte register file and
// returns a one-byte response. Define CMD_DISPATCH_ERRCNT_EN to build the NAK counter.
module cmd_dispatch #(
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [7:0]  ACK_BYTE   = 8'hA5,
    parameter logic [7:0]  NAK_BYTE   = 8'hEE,
    parameter logic [19:0] TX_TIMEOUT = 20'd1_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             cmd,
    input  logic                    cmd_rdy,
    output logic                    clr_cmd_rdy,
    output logic [7:0]              resp,
    output logic                    trmt,
    input  logic                    tx_done,
    output logic [NUM_REGS*8-1:0]   regs_flat,
    output logic                    busy,
    output logic                    tmo_err
);

    typedef enum logic [1:0] {StIdle, StExec, StSend, StWaitDone} state_e;

    state_e      state_q;
    logic [15:0] cmd_q;
    logic [19:0] tmo_cnt_q;
    logic [19:0] tmo_cnt_nxt;
    logic [7:0]  regs_q [NUM_REGS];

    logic [3:0]  op;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        addr_ok;
    logic [7:0]  rd_data;
    logic [7:0]  exec_resp;
    logic        do_write;
    logic        do_clear;
    logic        is_nak;

`ifdef CMD_DISPATCH_ERRCNT_EN
    logic [7:0]  errcnt_q;
`endif

    assign op          = cmd_q[15:12];
    assign addr        = cmd_q[11:8];
    assign data        = cmd_q[7:0];
    assign addr_ok     = 32'(addr) < NUM_REGS;
    assign tmo_cnt_nxt = tmo_cnt_q + 20'd1;

    assign clr_cmd_rdy = (state_q == StIdle) && cmd_rdy;
    assign busy        = (state_q != StIdle);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 4'(i)) rd_data = regs_q[i];
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[8*i +: 8] = regs_q[i];
        end
    end

    always_comb begin
        exec_resp = ACK_BYTE;
        do_write  = 1'b0;
        do_clear  = 1'b0;
        is_nak    = 1'b0;
        case (op)
            4'h1: begin
                if (addr_ok) do_write = 1'b1;
                else         is_nak   = 1'b1;
            end
            4'h2: begin
                if (addr_ok) exec_resp = rd_data;
                else         is_nak    = 1'b1;
            end
            4'h3: do_clear = 1'b1;
`ifdef CMD_DISPATCH_ERRCNT_EN
            4'h4: exec_resp = errcnt_q;
            4'h5: begin
            end
`endif
            default: is_nak = 1'b1;
        endcase
        if (is_nak) exec_resp = NAK_BYTE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            resp      <= '0;
            trmt      <= 1'b0;
            tmo_err   <= 1'b0;
            tmo_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef CMD_DISPATCH_ERRCNT_EN
            errcnt_q  <= '0;
`endif
        end else begin
            trmt <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_rdy) begin
                        cmd_q   <= cmd;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    resp <= exec_resp;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (do_clear)                         regs_q[i] <= '0;
                        else if (do_write && addr == 4'(i))   regs_q[i] <= data;
                    end
`ifdef CMD_DISPATCH_ERRCNT_EN
                    if (op == 4'h5)                         errcnt_q <= '0;
                    else if (is_nak && errcnt_q != 8'hFF)   errcnt_q <= errcnt_q + 8'd1;
`endif
                    // trmt rises together with the SEND state so it is high for exactly that cycle
                    trmt    <= 1'b1;
                    state_q <= StSend;
                end
                StSend: begin
                    tmo_cnt_q <= '0;
                    state_q   <= StWaitDone;
                end
                StWaitDone: begin
                    if (tx_done) begin
                        state_q <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_nxt;
                        if (tmo_cnt_nxt >= TX_TIMEOUT - 20'd1) begin
                            tmo_err <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch: randomized commands, behavioural register-file model,
// separate monitor that checks each transmitted response and the transaction length.
module tb_cmd_dispatch;

    localparam int          NR  = 8;
    localparam logic [19:0] TMO = 20'd16;
    localparam logic [7:0]  ACK = 8'hA5;
    localparam logic [7:0]  NAK = 8'hEE;

    logic            clk;
    logic            rst_n;
    logic [15:0]     cmd;
    logic            cmd_rdy;
    logic            clr_cmd_rdy;
    logic [7:0]      resp;
    logic            trmt;
    logic            tx_done;
    logic [NR*8-1:0] regs_flat;
    logic            busy;
    logic            tmo_err;

    cmd_dispatch #(
        .NUM_REGS  (NR),
        .ACK_BYTE  (ACK),
        .NAK_BYTE  (NAK),
        .TX_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .regs_flat  (regs_flat),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] m_regs [NR];
    logic [7:0] m_errcnt;
    bit         m_tmo;

    typedef struct {
        logic [7:0]      resp;
        logic [NR*8-1:0] regs;
        int              delay;
        bit              tmo;
        bit              tmo_sticky;
    } exp_t;
    exp_t exp_q[$];

    int tx_delay = 0;

    function automatic logic [NR*8-1:0] model_flat();
        logic [NR*8-1:0] f;
        for (int i = 0; i < NR; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_errcnt = 8'h00;
        m_tmo    = 1'b0;
    endtask

    task automatic model_exec(input logic [15:0] c, output logic [7:0] r);
        logic [3:0] op;
        int         a;
        bit         nak;
        op  = c[15:12];
        a   = int'(c[11:8]);
        nak = 1'b0;
        r   = ACK;
        case (op)
            4'h1: if (a < NR) m_regs[a] = c[7:0]; else nak = 1'b1;
            4'h2: if (a < NR) r = m_regs[a]; else nak = 1'b1;
            4'h3: for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
`ifdef CMD_DISPATCH_ERRCNT_EN
            4'h4: r = m_errcnt;
            4'h5: m_errcnt = 8'h00;
`endif
            default: nak = 1'b1;
        endcase
        if (nak) begin
            r = NAK;
            if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
        end
    endtask

    // Transmitter: clears tx_done on trmt, raises it tx_delay cycles into the wait
    initial begin
        int  cnt;
        bit  pend;
        cnt     = 0;
        pend    = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt) begin
                tx_done = 1'b0;
                cnt     = tx_delay;
                pend    = 1'b1;
            end else if (pend) begin
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    pend    = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: every trmt pops one expectation
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (rst_n && trmt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected trmt", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", 64'(resp), 64'(e.resp));
                    check("regs_flat at trmt", 64'(regs_flat), 64'(e.regs));
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (busy && k < 100);
                    check("cycles trmt to idle", 64'(k), e.tmo ? 64'(TMO) : 64'(e.delay + 2));
                    check("tmo_err", 64'(tmo_err), 64'(e.tmo_sticky));
                end
            end
        end
    end

    // Issue one command; caller is at a negedge with the DUT idle
    task automatic issue(input logic [15:0] c, input int delay, input bit hold);
        exp_t       e;
        logic [7:0] r;
        int         g;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("idle before issue", 64'd1, 64'd0);
        tx_delay = delay;
        model_exec(c, r);
        e.resp       = r;
        e.regs       = model_flat();
        e.delay      = delay;
        e.tmo        = (delay >= int'(TMO) - 1);
        m_tmo        = m_tmo | e.tmo;
        e.tmo_sticky = m_tmo;
        exp_q.push_back(e);
        cmd     = c;
        cmd_rdy = 1'b1;
        #1;
        check("clr_cmd_rdy on accept", 64'(clr_cmd_rdy), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) cmd_rdy = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
            if (busy && clr_cmd_rdy) check("clr_cmd_rdy while busy", 64'd1, 64'd0);
        end while (busy && g < 200);
        if (busy) check("transaction completes", 64'd1, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        logic [3:0]  op;
        int          d;
        int          r;
        rst_n   = 1'b0;
        cmd     = '0;
        cmd_rdy = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset trmt", 64'(trmt), 64'd0);
        check("reset resp", 64'(resp), 64'd0);
        check("reset tmo_err", 64'(tmo_err), 64'd0);
        check("reset regs", 64'(regs_flat), 64'd0);
        check("reset clr_cmd_rdy", 64'(clr_cmd_rdy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(16'h135A, 10, 1'b0);
        issue(16'h2300, 2, 1'b0);
        issue(16'h1F11, 0, 1'b0);
        issue(16'h9000, 1, 1'b0);
        for (int i = 0; i < 4; i++) issue({4'h1, 4'(i), 8'(8'h10 + i)}, 0, 1'b0);
        issue(16'h3000, 3, 1'b0);
        issue(16'h1777, 1, 1'b0);
        issue(16'h2700, 1000, 1'b0);
        issue(16'h1042, 3, 1'b0);
        issue(16'h1155, 14, 1'b1);
        issue(16'h2100, 15, 1'b1);
        issue(16'h2000, 1, 1'b0);
        cmd_rdy = 1'b0;
        issue(16'h8000, 0, 1'b0);
        issue(16'h1900, 0, 1'b0);
        issue(16'h2A00, 0, 1'b0);
        issue(16'h4000, 0, 1'b0);
        issue(16'h5000, 0, 1'b0);
        issue(16'h4000, 0, 1'b0);

        // Reset while a command sits in EXEC: nothing is transmitted
        cmd     = 16'h1266;
        cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        cmd_rdy = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no trmt after reset", 64'(trmt), 64'd0);
        end
        check("busy after reset", 64'(busy), 64'd0);
        check("regs after reset", 64'(regs_flat), 64'd0);
        check("tmo_err after reset", 64'(tmo_err), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)       op = 4'h1;
            else if (r < 6)  op = 4'h2;
            else if (r == 6) op = 4'h3;
            else if (r == 7) op = 4'h4;
            else if (r == 8) op = 4'h5;
            else             op = 4'($urandom_range(0, 15));
            c[15:12] = op;
            c[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15))
                                                   : 4'($urandom_range(0, 7));
            c[7:0]   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 4);
                d = (r == 0) ? 13 : (r == 1) ? 14 : (r == 2) ? 15 : (r == 3) ? 16 : 30;
            end else begin
                d = $urandom_range(0, 12);
            end
            issue(c, d, ($urandom_range(0, 3) == 0));
        end
        cmd_rdy = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
